// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the ALU op sequencer: opcodes, ALU control
// encodings, FSM state, NZP bit positions and the instruction field decoder.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] ctrl;
    logic [2:0] dr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [5:0] imm;
  } dec_t;

  // Unsupported opcodes decode to ALU_PASS so the ALU sees a neutral select.
  function automatic dec_t lc3_decode(input logic [15:0] word);
    dec_t d;
    d.legal = 1'b1;
    d.ctrl  = ALU_PASS;
    d.dr    = word[11:9];
    d.sr1   = word[8:6];
    d.sr2   = word[2:0];
    d.imm   = word[5:0];
    case (word[15:12])
      OP_ADD:  d.ctrl = ALU_ADD;
      OP_AND:  d.ctrl = ALU_AND;
      OP_NOT:  d.ctrl = ALU_NOT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the sequencer (slave) and its environment (master): the
// issue handshake, the ALU/register-file drives and the status outputs.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 16
);
    // instr is transferred on a rising edge where instr_valid && instr_ready;
    // the issuer must hold instr stable while instr_valid is high and unaccepted.
    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [2:0]        sr1_addr;
    logic [2:0]        sr2_addr;
    logic [5:0]        ir_imm;
    logic [1:0]        alu_control;
    logic [DATA_W-1:0] alu_out;
    logic              rf_we;
    logic [2:0]        dr_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        nzp;
    logic              done;
    logic              illegal;

    modport master (
        output instr_valid, instr, alu_out,
        input  instr_ready, sr1_addr, sr2_addr, ir_imm, alu_control,
               rf_we, dr_addr, rf_wdata, nzp, done, illegal
    );

    modport slave (
        input  instr_valid, instr, alu_out,
        output instr_ready, sr1_addr, sr2_addr, ir_imm, alu_control,
               rf_we, dr_addr, rf_wdata, nzp, done, illegal
    );

endinterface

// File: rtl/alu_op_sequencer_nzp_gen.sv
// Condition-code generator: sign/zero classification of a data word into
// one-hot {N,Z,P}.
module nzp_gen
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] value_i,
    output logic [2:0]        nzp_o
);

    always_comb begin
        nzp_o = 3'b000;
        if (value_i[DATA_W-1]) begin
            nzp_o[NZP_N] = 1'b1;
        end else if (value_i == '0) begin
            nzp_o[NZP_Z] = 1'b1;
        end else begin
            nzp_o[NZP_P] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state controller that runs one LC-3 ADD/AND/NOT through the external
// ALU and register file: accept, decode, execute, write back.
module alu_op_sequencer
    import lc3_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter logic [2:0] NZP_RESET = 3'b010
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus,
    output state_t              state_o
);

    state_t            state_q;
    logic [15:0]       ir_q;
    logic              instr_ready_q;
    logic [2:0]        sr1_q;
    logic [2:0]        sr2_q;
    logic [5:0]        imm_q;
    logic [1:0]        ctrl_q;
    logic [2:0]        dr_q;
    logic [DATA_W-1:0] result_q;
    logic              rf_we_q;
    logic              done_q;
    logic              illegal_q;
    logic [2:0]        nzp_q;
    logic [2:0]        nzp_d;

    dec_t dec_in;
    dec_t dec_ir;

    assign dec_in = lc3_decode(bus.instr);
    assign dec_ir = lc3_decode(ir_q);

    nzp_gen #(
        .DATA_W (DATA_W)
    ) u_nzp_gen (
        .value_i (result_q),
        .nzp_o   (nzp_d)
    );

    // Drives are loaded on the accept edge so they are already valid during
    // DECODE; DECODE reloads them from ir_q, which yields the same values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ir_q          <= '0;
            instr_ready_q <= 1'b1;
            sr1_q         <= '0;
            sr2_q         <= '0;
            imm_q         <= '0;
            ctrl_q        <= ALU_PASS;
            dr_q          <= '0;
            result_q      <= '0;
            rf_we_q       <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            nzp_q         <= NZP_RESET;
        end else begin
            rf_we_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid && instr_ready_q) begin
                        ir_q          <= bus.instr;
                        sr1_q         <= dec_in.sr1;
                        sr2_q         <= dec_in.sr2;
                        imm_q         <= dec_in.imm;
                        ctrl_q        <= dec_in.ctrl;
                        dr_q          <= dec_in.dr;
                        illegal_q     <= ~dec_in.legal;
                        instr_ready_q <= 1'b0;
                        state_q       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_ir.legal) begin
                        sr1_q   <= dec_ir.sr1;
                        sr2_q   <= dec_ir.sr2;
                        imm_q   <= dec_ir.imm;
                        ctrl_q  <= dec_ir.ctrl;
                        dr_q    <= dec_ir.dr;
                        state_q <= ST_EXEC;
                    end else begin
                        ctrl_q        <= ALU_PASS;
                        instr_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    result_q <= bus.alu_out;
                    rf_we_q  <= 1'b1;
                    done_q   <= 1'b1;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    nzp_q         <= nzp_d;
                    ctrl_q        <= ALU_PASS;
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    ctrl_q        <= ALU_PASS;
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.sr1_addr    = sr1_q;
    assign bus.sr2_addr    = sr2_q;
    assign bus.ir_imm      = imm_q;
    assign bus.alu_control = ctrl_q;
    assign bus.dr_addr     = dr_q;
    assign bus.rf_wdata    = result_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.nzp         = nzp_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a register-file/ALU environment
// model, a scoreboard queue and a decoupled output monitor.
module tb_alu_op_sequencer;
    import lc3_pkg::*;

    localparam int W = 23;  // {illegal, dr[2:0], wdata[15:0], nzp_after[2:0]}

    logic   clk;
    logic   reset;
    state_t state_o;
    int     cyc;
    int     n_checks;
    int     n_errors;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic [15:0]  rf[8];

    alu_op_sequencer_if #(.DATA_W(16)) bus ();

    alu_op_sequencer #(
        .DATA_W    (16),
        .NZP_RESET (3'b010)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment: register file + ALU ----------------
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            rf[1] <= 16'h0005;
            rf[2] <= 16'h0003;
        end else if (bus.rf_we) begin
            rf[bus.dr_addr] <= bus.rf_wdata;
        end
    end

    logic [15:0] alu_b;
    always_comb begin
        alu_b = bus.ir_imm[5] ? {{11{bus.ir_imm[4]}}, bus.ir_imm[4:0]} : rf[bus.sr2_addr];
        case (bus.alu_control)
            2'b01:   bus.alu_out = rf[bus.sr1_addr] + alu_b;
            2'b10:   bus.alu_out = rf[bus.sr1_addr] & alu_b;
            2'b11:   bus.alu_out = ~rf[bus.sr1_addr];
            default: bus.alu_out = rf[bus.sr1_addr];
        endcase
    end

    always @(posedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) acc_q.push_back(cyc);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic       nzp_pend;
    logic [2:0] nzp_exp_m;
    initial nzp_pend = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (nzp_pend) begin
            check("mon_nzp_after", {29'd0, bus.nzp}, {29'd0, nzp_exp_m});
            nzp_pend = 1'b0;
        end
        if (!reset && (bus.rf_we || bus.illegal)) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e[22]) begin
                    check("mon_illegal", {31'd0, bus.illegal}, 32'd1);
                    check("mon_no_write_on_illegal", {31'd0, bus.rf_we}, 32'd0);
                end else begin
                    check("mon_rf_we", {31'd0, bus.rf_we}, 32'd1);
                    check("mon_done", {31'd0, bus.done}, 32'd1);
                    check("mon_dr_addr", {29'd0, bus.dr_addr}, {29'd0, e[21:19]});
                    check("mon_rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, e[18:3]});
                end
                nzp_exp_m = e[2:0];
                nzp_pend  = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [15:0] word, input logic ill, input logic [2:0] dr,
                         input logic [15:0] wd, input logic [2:0] nz);
        bit accepted;
        exp_q.push_back({ill, dr, wd, nz});
        @(negedge clk);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(posedge clk);
            if (bus.instr_ready) accepted = 1'b1;
        end
        #1;
        bus.instr_valid = 1'b0;
        if (!accepted) check("issue_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (bus.instr_ready) idle = 1'b1;
        end
        if (!idle) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr_ready"}, {31'd0, bus.instr_ready}, 32'd1);
        check({tag, "_state"}, {30'd0, state_o}, {30'd0, ST_IDLE});
        check({tag, "_sr1_addr"}, {29'd0, bus.sr1_addr}, 32'd0);
        check({tag, "_sr2_addr"}, {29'd0, bus.sr2_addr}, 32'd0);
        check({tag, "_dr_addr"}, {29'd0, bus.dr_addr}, 32'd0);
        check({tag, "_ir_imm"}, {26'd0, bus.ir_imm}, 32'd0);
        check({tag, "_alu_control"}, {30'd0, bus.alu_control}, 32'd0);
        check({tag, "_rf_wdata"}, {16'd0, bus.rf_wdata}, 32'd0);
        check({tag, "_rf_we"}, {31'd0, bus.rf_we}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
        check({tag, "_nzp"}, {29'd0, bus.nzp}, 32'h2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int viol;
        n_checks        = 0;
        n_errors        = 0;
        cyc             = 0;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: ADD R0,R1,R2 = 5+3, write lands in the third cycle after accept
        issue(16'h1042, 1'b0, 3'd0, 16'h0008, 3'b001);
        @(negedge clk);
        check("t1_decode_no_we", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        check("t1_exec_no_we", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        check("t1_wb_we", {31'd0, bus.rf_we}, 32'd1);
        wait_idle();

        // 2: ADD R3,R1,#-1, drives held from DECODE through WB
        issue(16'h167F, 1'b0, 3'd3, 16'h0004, 3'b001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_state", {30'd0, state_o}, 32'(k + 1));
            check("t2_alu_control", {30'd0, bus.alu_control}, 32'h1);
            check("t2_ir_imm", {26'd0, bus.ir_imm}, 32'h3F);
            check("t2_sr1_addr", {29'd0, bus.sr1_addr}, 32'd1);
            check("t2_dr_addr", {29'd0, bus.dr_addr}, 32'd3);
        end
        wait_idle();
        check("t2_idle_alu_control", {30'd0, bus.alu_control}, 32'h0);
        check("t2_idle_dr_hold", {29'd0, bus.dr_addr}, 32'd3);

        // 3: AND R4,R1,#0 then NOT R5,R1
        issue(16'h5860, 1'b0, 3'd4, 16'h0000, 3'b010);
        wait_idle();
        issue(16'h9A7F, 1'b0, 3'd5, 16'hFFFA, 3'b100);
        wait_idle();

        // 4: opcode 0000 is illegal; nzp stays 100
        issue(16'h0000, 1'b1, 3'd0, 16'h0000, 3'b100);
        @(negedge clk);
        check("t4_illegal_pulse", {31'd0, bus.illegal}, 32'd1);
        check("t4_ready_low", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clk);
        check("t4_ready_again", {31'd0, bus.instr_ready}, 32'd1);
        check("t4_illegal_cleared", {31'd0, bus.illegal}, 32'd0);
        check("t4_state_idle", {30'd0, state_o}, {30'd0, ST_IDLE});

        // 5: ADD R0,R0,R0 three times with valid held: 8 -> 16 -> 32 -> 64
        exp_q.push_back({1'b0, 3'd0, 16'h0010, 3'b001});
        exp_q.push_back({1'b0, 3'd0, 16'h0020, 3'b001});
        exp_q.push_back({1'b0, 3'd0, 16'h0040, 3'b001});
        base = acc_q.size();
        viol = 0;
        @(negedge clk);
        bus.instr       = 16'h1000;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 40 && acc_q.size() < base + 3; i++) begin
            @(negedge clk);
            if (state_o != ST_IDLE && bus.instr_ready) viol++;
        end
        bus.instr_valid = 1'b0;
        check("t5_accept_count", 32'(acc_q.size() - base), 32'd3);
        if (acc_q.size() >= base + 3) begin
            check("t5_gap_1", 32'(acc_q[base+1] - acc_q[base]), 32'd4);
            check("t5_gap_2", 32'(acc_q[base+2] - acc_q[base+1]), 32'd4);
        end
        check("t5_ready_low_busy", 32'(viol), 32'd0);
        wait_idle();

        // 6: reset during EXEC discards the instruction immediately
        @(negedge clk);
        bus.instr       = 16'h1042;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_in_exec", {30'd0, state_o}, {30'd0, ST_EXEC});
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        repeat (2) @(negedge clk);
        check("t6_no_we_in_reset", {31'd0, bus.rf_we}, 32'd0);
        reset = 1'b0;
        issue(16'h1042, 1'b0, 3'd0, 16'h0008, 3'b001);
        wait_idle();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
